tow_round_ctrl: RTL and testbench

Round sequencer and first-press arbiter for the tug-of-war game. Owns the clear lines of the two player press latches, runs a countdown / go / hold round cycle, decides which latch set first, and moves a signed rope position one step per won round until a player reaches the end. Sits between the two press latches and the display/score logic.

---
 rtl/tow_round_ctrl_if.sv | 28 ++
 rtl/tow_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_tow_round_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tow_round_ctrl_if.sv
// Bundle between the round sequencer and the press latches / display logic.
// The master side is the sequencer; the slave side is the latches plus score logic.
interface tow_round_ctrl_if #(
    parameter int POS_W = 4
);
    logic                    start;
    logic                    latch_l;
    logic                    latch_r;
    logic                    clr_l;
    logic                    clr_r;
    logic                    go;
    logic signed [POS_W-1:0] pos;
    logic                    point_l;
    logic                    point_r;
    logic                    winner_l;
    logic                    winner_r;
    logic [2:0]              state;

    modport master (
        input  start, latch_l, latch_r,
        output clr_l, clr_r, go, pos, point_l, point_r, winner_l, winner_r, state
    );

    modport slave (
        output start, latch_l, latch_r,
        input  clr_l, clr_r, go, pos, point_l, point_r, winner_l, winner_r, state
    );
endinterface

// File: rtl/tow_round_ctrl.sv
// Tug-of-war round sequencer and first-press arbiter; optional early-press fouls under TOW_FOUL_EN.
// Latency: one cycle from a sampled latch to the registered point pulse and pos update.
// Backpressure: none; latches are held cleared outside the open window, start is ignored mid-game.
module tow_round_ctrl #(
    parameter int GO_DELAY    = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int POS_MAX     = 4,
    parameter int POS_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    tow_round_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_GO    = 3'd3,
        S_HOLD  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam int CNT_MAX = (GO_DELAY > HOLD_CYCLES) ? GO_DELAY : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [POS_W-1:0] ONE  = POS_W'(1);
    localparam logic signed [POS_W-1:0] PMAX = POS_W'(POS_MAX);
    localparam logic signed [POS_W-1:0] NMAX = POS_W'(-POS_MAX);

`ifdef TOW_FOUL_EN
    localparam logic WAIT_CLR = 1'b0;
`else
    localparam logic WAIT_CLR = 1'b1;
`endif

    state_t                  st;
    logic [CNT_W-1:0]        cnt;
    logic signed [POS_W-1:0] pos;
    logic                    clr_l, clr_r, go;
    logic                    point_l, point_r;
    logic                    winner_l, winner_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            cnt      <= '0;
            pos      <= '0;
            clr_l    <= 1'b1;
            clr_r    <= 1'b1;
            go       <= 1'b0;
            point_l  <= 1'b0;
            point_r  <= 1'b0;
            winner_l <= 1'b0;
            winner_r <= 1'b0;
        end else begin
            point_l <= 1'b0;
            point_r <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (bus.start) begin
                        pos <= '0;
                        st  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt   <= CNT_W'(GO_DELAY - 1);
                    clr_l <= WAIT_CLR;
                    clr_r <= WAIT_CLR;
                    st    <= S_WAIT;
                end
                S_WAIT: begin
`ifdef TOW_FOUL_EN
                    // An early press hands the round to the opponent; a double foul scores nothing.
                    if (bus.latch_l || bus.latch_r) begin
                        if (bus.latch_l && !bus.latch_r) begin
                            point_r <= 1'b1;
                            pos     <= pos + ONE;
                        end else if (bus.latch_r && !bus.latch_l) begin
                            point_l <= 1'b1;
                            pos     <= pos - ONE;
                        end
                        cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        clr_l <= 1'b1;
                        clr_r <= 1'b1;
                        st    <= S_HOLD;
                    end else
`endif
                    if (cnt == '0) begin
                        go    <= 1'b1;
                        clr_l <= 1'b0;
                        clr_r <= 1'b0;
                        st    <= S_GO;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GO: begin
                    if (bus.latch_l || bus.latch_r) begin
                        if (bus.latch_l && !bus.latch_r) begin
                            point_l <= 1'b1;
                            pos     <= pos - ONE;
                        end else if (bus.latch_r && !bus.latch_l) begin
                            point_r <= 1'b1;
                            pos     <= pos + ONE;
                        end
                        cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        go    <= 1'b0;
                        clr_l <= 1'b1;
                        clr_r <= 1'b1;
                        st    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        if (pos == PMAX || pos == NMAX) begin
                            winner_l <= (pos == NMAX);
                            winner_r <= (pos == PMAX);
                            st       <= S_OVER;
                        end else begin
                            st <= S_CLEAR;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_OVER: begin
                    if (bus.start) begin
                        pos      <= '0;
                        winner_l <= 1'b0;
                        winner_r <= 1'b0;
                        st       <= S_CLEAR;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign bus.state    = st;
    assign bus.pos      = pos;
    assign bus.clr_l    = clr_l;
    assign bus.clr_r    = clr_r;
    assign bus.go       = go;
    assign bus.point_l  = point_l;
    assign bus.point_r  = point_r;
    assign bus.winner_l = winner_l;
    assign bus.winner_r = winner_r;
endmodule

// File: tb/tb_tow_round_ctrl.sv
// Bench for tow_round_ctrl: directed scenarios plus randomized rounds scored against a round-level model.
module tb_tow_round_ctrl;
    localparam int GO_DELAY    = 4;
    localparam int HOLD_CYCLES = 3;
    localparam int POS_MAX     = 2;
    localparam int POS_W       = 4;
`ifdef TOW_FOUL_EN
    localparam bit FOUL = 1'b1;
`else
    localparam bit FOUL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_pos = 0;

    tow_round_ctrl_if #(.POS_W(POS_W)) ifc ();

    tow_round_ctrl #(
        .GO_DELAY(GO_DELAY), .HOLD_CYCLES(HOLD_CYCLES), .POS_MAX(POS_MAX), .POS_W(POS_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.master)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish, got running / required finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ifc.start = 1'b0; ifc.latch_l = 1'b0; ifc.latch_r = 1'b0;
        step(); step();
        rst = 1'b0;
        model_pos = 0;
    endtask

    task automatic do_start();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        model_pos = 0;
        n_cmp++; if (ifc.state !== 3'd1) begin n_bad++; $display("FAIL start_state got %0d want 1", ifc.state); end
        n_cmp++; if (int'(ifc.pos) !== 0) begin n_bad++; $display("FAIL start_pos got %0d want 0", int'(ifc.pos)); end
        n_cmp++; if ({ifc.winner_l, ifc.winner_r} !== 2'b00) begin n_bad++; $display("FAIL start_winners got %b want 00", {ifc.winner_l, ifc.winner_r}); end
    endtask

    // One full round from an observed CLEAR: countdown, gap idle GO cycles, press, hold.
    task automatic run_round(input int gap, input bit pl, input bit pr, input bit noise);
        bit over;
        n_cmp++; if (ifc.state !== 3'd1 || {ifc.clr_l, ifc.clr_r} !== 2'b11) begin n_bad++; $display("FAIL rnd_clear state %0d clr %b want 1 11", ifc.state, {ifc.clr_l, ifc.clr_r}); end
        step();
        for (int i = 0; i < GO_DELAY; i++) begin
            n_cmp++; if (ifc.state !== 3'd2 || ifc.go !== 1'b0) begin n_bad++; $display("FAIL rnd_wait[%0d] state %0d go %b want 2 0", i, ifc.state, ifc.go); end
            n_cmp++; if (ifc.clr_l !== !FOUL || ifc.clr_r !== !FOUL) begin n_bad++; $display("FAIL rnd_wait_clr[%0d] got %b%b want %0d", i, ifc.clr_l, ifc.clr_r, !FOUL); end
            if (noise) ifc.start = 1'($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < gap; i++) begin
            n_cmp++; if (ifc.state !== 3'd3 || ifc.go !== 1'b1 || {ifc.clr_l, ifc.clr_r} !== 2'b00) begin n_bad++; $display("FAIL rnd_go[%0d] state %0d go %b clr %b%b want 3 1 00", i, ifc.state, ifc.go, ifc.clr_l, ifc.clr_r); end
            n_cmp++; if ({ifc.point_l, ifc.point_r} !== 2'b00) begin n_bad++; $display("FAIL rnd_go_pt[%0d] got %b want 00", i, {ifc.point_l, ifc.point_r}); end
            if (noise) ifc.start = 1'($urandom_range(0, 1));
            step();
        end
        n_cmp++; if (ifc.state !== 3'd3 || ifc.go !== 1'b1) begin n_bad++; $display("FAIL rnd_go_open state %0d go %b want 3 1", ifc.state, ifc.go); end
        ifc.start = 1'b0;
        ifc.latch_l = pl; ifc.latch_r = pr;
        step();
        ifc.latch_l = 1'b0; ifc.latch_r = 1'b0;
        if (pl != pr) model_pos += pr ? 1 : -1;
        n_cmp++; if (ifc.point_l !== (pl && !pr) || ifc.point_r !== (pr && !pl)) begin n_bad++; $display("FAIL rnd_point got %b%b want %b%b", ifc.point_l, ifc.point_r, pl && !pr, pr && !pl); end
        n_cmp++; if (int'(ifc.pos) !== model_pos) begin n_bad++; $display("FAIL rnd_pos got %0d want %0d", int'(ifc.pos), model_pos); end
        n_cmp++; if (ifc.state !== 3'd4 || ifc.go !== 1'b0 || {ifc.clr_l, ifc.clr_r} !== 2'b11) begin n_bad++; $display("FAIL rnd_hold state %0d go %b clr %b%b want 4 0 11", ifc.state, ifc.go, ifc.clr_l, ifc.clr_r); end
        for (int i = 1; i < HOLD_CYCLES; i++) begin
            step();
            n_cmp++; if (ifc.state !== 3'd4 || {ifc.point_l, ifc.point_r} !== 2'b00) begin n_bad++; $display("FAIL rnd_hold[%0d] state %0d pt %b%b want 4 00", i, ifc.state, ifc.point_l, ifc.point_r); end
        end
        step();
        over = (model_pos == POS_MAX) || (model_pos == -POS_MAX);
        n_cmp++; if (ifc.state !== (over ? 3'd5 : 3'd1)) begin n_bad++; $display("FAIL rnd_after_hold got %0d want %0d", ifc.state, over ? 5 : 1); end
        n_cmp++; if (ifc.winner_l !== (over && model_pos < 0) || ifc.winner_r !== (over && model_pos > 0)) begin n_bad++; $display("FAIL rnd_winner got %b%b want %b%b", ifc.winner_l, ifc.winner_r, over && model_pos < 0, over && model_pos > 0); end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (ifc.state !== 3'd0 || int'(ifc.pos) !== 0 || {ifc.clr_l, ifc.clr_r} !== 2'b11) begin n_bad++; $display("FAIL reset_idle[%0d] state %0d pos %0d clr %b%b want 0 0 11", i, ifc.state, int'(ifc.pos), ifc.clr_l, ifc.clr_r); end
            n_cmp++; if ({ifc.go, ifc.point_l, ifc.point_r, ifc.winner_l, ifc.winner_r} !== 5'b0) begin n_bad++; $display("FAIL reset_outs[%0d] got %b want 00000", i, {ifc.go, ifc.point_l, ifc.point_r, ifc.winner_l, ifc.winner_r}); end
        end
    endtask

    task automatic test_right_point();
        do_reset();
        do_start();
        run_round(3, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_left_wins();
        do_reset();
        do_start();
        run_round(0, 1'b1, 1'b0, 1'b0);
        run_round(2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (ifc.state !== 3'd5 || ifc.winner_l !== 1'b1 || ifc.winner_r !== 1'b0) begin n_bad++; $display("FAIL over_hold[%0d] state %0d win %b%b want 5 10", i, ifc.state, ifc.winner_l, ifc.winner_r); end
            n_cmp++; if (int'(ifc.pos) !== -POS_MAX || {ifc.clr_l, ifc.clr_r} !== 2'b11) begin n_bad++; $display("FAIL over_pos[%0d] pos %0d clr %b%b want %0d 11", i, int'(ifc.pos), ifc.clr_l, ifc.clr_r, -POS_MAX); end
        end
        do_start();
    endtask

    task automatic test_tie();
        run_round(1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_early_press();
        do_reset();
        do_start();
        step();
        step();
        ifc.latch_l = 1'b1;
        step();
        ifc.latch_l = 1'b0;
        if (FOUL) begin
            n_cmp++; if (ifc.point_r !== 1'b1 || ifc.point_l !== 1'b0 || int'(ifc.pos) !== 1) begin n_bad++; $display("FAIL foul_point pt %b%b pos %0d want 01 1", ifc.point_l, ifc.point_r, int'(ifc.pos)); end
            n_cmp++; if (ifc.state !== 3'd4) begin n_bad++; $display("FAIL foul_hold got %0d want 4", ifc.state); end
            for (int i = 0; i < HOLD_CYCLES; i++) begin
                n_cmp++; if (ifc.go !== 1'b0) begin n_bad++; $display("FAIL foul_go[%0d] got %b want 0", i, ifc.go); end
                step();
            end
            n_cmp++; if (ifc.state !== 3'd1 || ifc.go !== 1'b0) begin n_bad++; $display("FAIL foul_next state %0d go %b want 1 0", ifc.state, ifc.go); end
        end else begin
            n_cmp++; if ({ifc.point_l, ifc.point_r} !== 2'b00 || int'(ifc.pos) !== 0) begin n_bad++; $display("FAIL early_ignored pt %b%b pos %0d want 00 0", ifc.point_l, ifc.point_r, int'(ifc.pos)); end
            n_cmp++; if (ifc.state !== 3'd2 || ifc.clr_l !== 1'b1) begin n_bad++; $display("FAIL early_wait state %0d clr_l %b want 2 1", ifc.state, ifc.clr_l); end
            step();
            n_cmp++; if (ifc.state !== 3'd2 || ifc.go !== 1'b0) begin n_bad++; $display("FAIL early_wait4 state %0d go %b want 2 0", ifc.state, ifc.go); end
            step();
            n_cmp++; if (ifc.state !== 3'd3 || ifc.go !== 1'b1) begin n_bad++; $display("FAIL early_go state %0d go %b want 3 1", ifc.state, ifc.go); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        for (int i = 0; i <= GO_DELAY; i++) step();
        n_cmp++; if (ifc.state !== 3'd3) begin n_bad++; $display("FAIL mid_in_go got %0d want 3", ifc.state); end
        ifc.latch_l = 1'b1; rst = 1'b1;
        step();
        n_cmp++; if (ifc.state !== 3'd0 || int'(ifc.pos) !== 0 || ifc.point_l !== 1'b0) begin n_bad++; $display("FAIL mid_reset state %0d pos %0d point_l %b want 0 0 0", ifc.state, int'(ifc.pos), ifc.point_l); end
        n_cmp++; if (ifc.go !== 1'b0 || {ifc.clr_l, ifc.clr_r} !== 2'b11) begin n_bad++; $display("FAIL mid_reset_outs go %b clr %b%b want 0 11", ifc.go, ifc.clr_l, ifc.clr_r); end
        ifc.latch_l = 1'b0; ifc.start = 1'b1;
        step();
        n_cmp++; if (ifc.state !== 3'd0) begin n_bad++; $display("FAIL rst_beats_start got %0d want 0", ifc.state); end
        ifc.start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_random();
        int k;
        do_reset();
        do_start();
        for (int r = 0; r < 24; r++) begin
            k = int'($urandom_range(0, 2));
            run_round(int'($urandom_range(0, 4)), k != 1, k != 0, 1'b1);
            if (model_pos == POS_MAX || model_pos == -POS_MAX) do_start();
        end
    endtask

    initial begin
        ifc.start = 1'b0; ifc.latch_l = 1'b0; ifc.latch_r = 1'b0;
        test_reset();
        test_right_point();
        test_left_wins();
        test_tie();
        test_early_press();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
